// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// CLK_FREQ and BAUD_RATE are shared with the baud tick generator.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEFAULT    = 8;
  localparam int unsigned OVERSAMPLING_DEFAULT = 16;
  localparam int unsigned CLK_FREQ             = 100_000_000;
  localparam int unsigned BAUD_RATE            = 115_200;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: LSB-first data, one stop bit, no parity.
// Samples mid-bit by counting baud ticks; o_valid/o_frame_err are one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int unsigned OVERSAMPLING = OVERSAMPLING_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_aresetn,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLING);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLING / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLING - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync_rx (
    .clk_i  (i_clk),
    .rst_ni (i_aresetn),
    .d_i    (i_rx),
    .q_o    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (i_baud_tick) begin
          if (cnt_q == HalfLast) begin
            // Line back high by mid start bit: treat as a glitch.
            state_d = rx_s ? StIdle : StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (i_baud_tick) begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IdxLast) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (i_baud_tick) begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            state_d = StIdle;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLING, default 16, baud ticks per bit period (even, >=8).
REQ-003 SHALL have port i_clk, input, 1, single clock for all logic.
REQ-004 SHALL have port i_aresetn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port i_baud_tick, input, 1, one-cycle strobe at BAUD_RATE*OVERSAMPLING, from the team's baud tick generator.
REQ-006 SHALL have port i_rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port o_data, output, DATA_BITS, last correctly framed received word.
REQ-008 SHALL have port o_valid, output, 1, one-cycle pulse: o_data updated.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer, reset to 1; all sampling uses the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; a 4-bit tick counter (width clog2(OVERSAMPLING)) and a bit index counter.
REQ-013 IDLE: when rx_s==0 (any cycle, tick not required), go to START and clear the tick counter.
REQ-014 START: on each i_baud_tick, increment the tick counter; at tick count OVERSAMPLING/2-1, if rx_s==0, go to DATA and clear the tick counter and bit index; otherwise return to IDLE as a glitch (no outputs).
REQ-015 DATA: on each i_baud_tick, increment the tick counter; at OVERSAMPLING-1, sample rx_s into the shift register LSB-first (shift right, insert at MSB) and wrap the tick counter to 0; after bit DATA_BITS-1, go to STOP.
REQ-016 STOP: at tick count OVERSAMPLING-1, if rx_s==1, load o_data from the shift register and pulse o_valid the next cycle; if rx_s==0, pulse o_frame_err and leave o_data unchanged; in both cases return to IDLE.
REQ-017 The tick counter SHALL advance only on i_baud_tick; cycles without a tick hold all state.
REQ-018 o_valid and o_frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one i_clk cycle per frame.
REQ-019 After STOP, IDLE SHALL accept a new start edge immediately, so back-to-back frames are received with zero idle bits.
REQ-020 A line held low in IDLE after a frame error (break) SHALL start a new frame; the result is a repeated frame error per frame period.
REQ-021 o_data SHALL hold its value until the next valid frame; there is no consumer backpressure, and an unread word is overwritten.

Reset
REQ-022 When i_aresetn==0 on a rising i_clk edge: FSM=IDLE, counters=0, shift register=0, synchronizer=1, o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no o_valid or o_frame_err pulse; reception resumes with the next start edge after release.

Structure
REQ-024 Package uart_pkg SHALL hold the rx state enum typedef, the default DATA_BITS and OVERSAMPLING values, and the default CLK_FREQ/BAUD_RATE constants shared with the baud tick generator.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff (parameter reset value).
REQ-026 The bench SHALL drive i_baud_tick from the existing baud tick generator with CLK_FREQ=100 MHz and BAUD_RATE=115200 (tick every 54 clocks).

Verification
REQ-027 Send 0xA5 (8N1) -> one o_valid pulse, o_data=0xA5, o_frame_err never asserted.
REQ-028 Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three o_valid pulses with data 0x00, 0xFF, 0x3C in order.
REQ-029 Low glitch of 3 tick periods while idle -> FSM returns to IDLE, no o_valid or o_frame_err pulse, and the next frame 0x5A is received correctly.
REQ-030 Send 0x81 with the stop bit forced low -> one o_frame_err pulse, no o_valid pulse, and o_data keeps its previous value.
REQ-031 Assert reset during data bit 4 of 0xC3, release it, then send 0x7E -> no pulse for the aborted frame, o_valid with o_data=0x7E.
REQ-032 Baud rate offset +/-3% on the sender for 0x55 -> o_data=0x55 with no frame error.
